shift_seq: RTL
==============

Name: shift_seq

Overview:
- Multi-cycle x86 shift unit for SAL/SHL, SHR and SAR on byte or word operands.
- Shifts one bit per clock and uses a start/busy/done handshake.
- Sits beside the combinational rotate unit in the ALU path. The microcode sequencer stalls on busy.
- Produces the result plus CF, OF, SF, ZF and PF, and a flag-update qualifier.

Parameters:
- none (operand width fixed at 16; byte mode selected by word_op)

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- start  input  1  request; sampled only when busy==0
- x  input  16  operand; byte ops use x[7:0]
- y  input  5  shift count (80186 semantics: y[4:0], 0..31)
- func  input  2  00 SHL/SAL, 01 SHR, 10 SAR, 11 SAL (same as 00)
- word_op  input  1  1 = word, 0 = byte
- cfi  input  1  incoming CF
- ofi  input  1  incoming OF
- busy  output  1  shifting in progress
- done  output  1  one-cycle pulse; result valid
- out  output  16  result; byte ops pass x[15:8] through
- cfo  output  1  carry out
- ofo  output  1  overflow out
- sfo  output  1  sign of result (bit 15 or bit 7)
- zfo  output  1  result zero (16 or low 8 bits)
- pfo  output  1  even parity of out[7:0]
- flags_upd  output  1  1 = flag outputs must be written to FLAGS

Behaviour:
- Reset values: all outputs 0; state IDLE. Reset mid-shift aborts the operation with no done pulse.
- States:
  - IDLE: start → latch x, func, word_op, cfi, ofi and cnt = y. If cnt==0 → DONE, else → SHIFT.
  - SHIFT: busy=1. Each cycle performs one step and decrements cnt. When the step with cnt==1 is performed → DONE.
  - DONE: done=1 for exactly one cycle; busy=0. start is accepted here, same as IDLE. Next state is SHIFT/DONE per the new count if start, else IDLE.
- Latency: done is high count+1 cycles after the start cycle; count 0 gives 1 cycle.
- out and the flags hold their value from done until the next accepted start.
- start while busy: ignored, with no queueing.
- Inputs are latched at start; later changes to x, y, func, word_op, cfi or ofi have no effect on the operation in progress.
- One step, on width W = 16 or 8 with v = working value:
  - SHL: cf ← v[W-1]; v ← v<<1.
  - SHR: cf ← v[0]; v ← v>>1, zero fill.
  - SAR: cf ← v[0]; v ← v>>1, sign fill.
- Large counts (count ≥ W) fall out naturally from stepping:
  - SHL/SHR: result 0; CF = last bit out (e.g. word SHL by 16 → CF=x[0]; by 17 → CF=0).
  - SAR: all sign bits.
- count==0: out=x, cfo=cfi, ofo=ofi, flags_upd=0; sfo/zfo/pfo computed from x but not written.
- count>0: flags_upd=1.
- OF, computed on the final step:
  - SHL: msb(result) ^ cfo.
  - SHR: msb of the value before the final step.
  - SAR: 0.
- AF is not produced; the sequencer leaves it unchanged.

Decomposition:
- Shared ALU package holds:
  - func codes (SHF_SHL=2'b00, SHF_SHR=2'b01, SHF_SAR=2'b10, SHF_SAL=2'b11);
  - state encoding (IDLE, SHIFT, DONE);
  - the 5-bit count width.
- One combinational sub-module, shift_step: single-bit step over 16 bits with word_op select. Outputs the next value, cf and prev_msb. Instantiated once in the datapath; the FSM, counter and flag logic stay in shift_seq.

Test Plan:
- Word SHL, x=16'h8001, y=1 → done 2 cycles after start; out=16'h0002, cfo=1, ofo=1, sfo=0, zfo=0, pfo=0, flags_upd=1.
- Byte SAR, x=16'hAB80, y=3 → done at start+4; out=16'hABF0, cfo=0, ofo=0, sfo=1, zfo=0, pfo=1; busy high for 3 cycles.
- Word SHR, x=16'h0001, y=1 → out=16'h0000, cfo=1, ofo=0, zfo=1, pfo=1.
- Count zero, x=16'h1234, y=0, cfi=1, ofi=1 → done at start+1; out=16'h1234, cfo=1, ofo=1, flags_upd=0, busy never high.
- Word SHL, x=16'hFFFF, y=20; start re-pulsed with y=1 during busy → first op only; done at start+21, out=16'h0000, cfo=0. A back-to-back start in the DONE cycle completes correctly.
- rst asserted on the 3rd SHIFT cycle of y=10 → next cycle busy=0, done=0, out=0, no done pulse. A following start with x=16'h0003, y=1 SHL → out=16'h0006.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// Shared ALU definitions for the multi-cycle shift unit: function codes,
// sequencer states, count width and the result-flag helper.
package shift_seq_pkg;

  localparam int unsigned CNT_W  = 5;
  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {
    SHF_SHL = 2'b00,
    SHF_SHR = 2'b01,
    SHF_SAR = 2'b10,
    SHF_SAL = 2'b11
  } shf_func_e;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } shf_state_e;

  typedef struct packed {
    logic sf;
    logic zf;
    logic pf;
  } res_flags_t;

  // SF/ZF follow the operand width; PF always looks at the low byte only.
  function automatic res_flags_t res_flags(input logic [DATA_W-1:0] v,
                                           input logic              word_op);
    res_flags_t f;
    f.sf = word_op ? v[15] : v[7];
    f.zf = word_op ? (v == '0) : (v[7:0] == '0);
    f.pf = ~^v[7:0];
    return f;
  endfunction

endpackage

// File: rtl/shift_seq_step.sv
// Single-bit shift step over 16 bits; byte mode leaves v[15:8] untouched.
module shift_step
  import shift_seq_pkg::*;
(
  input  logic [DATA_W-1:0] v,
  input  shf_func_e         func,
  input  logic              word_op,
  output logic [DATA_W-1:0] v_next,
  output logic              cf,
  output logic              prev_msb
);

  logic fill;

  always_comb begin
    prev_msb = word_op ? v[15] : v[7];
    fill     = 1'b0;
    v_next   = v;
    cf       = 1'b0;
    case (func)
      SHF_SHR, SHF_SAR: begin
        cf   = v[0];
        fill = (func == SHF_SAR) & prev_msb;
        if (word_op) v_next = {fill, v[15:1]};
        else         v_next = {v[15:8], fill, v[7:1]};
      end
      default: begin
        cf = prev_msb;
        if (word_op) v_next = {v[14:0], 1'b0};
        else         v_next = {v[15:8], v[6:0], 1'b0};
      end
    endcase
  end

endmodule

// File: rtl/shift_seq.sv
// Multi-cycle SAL/SHL/SHR/SAR unit: one bit per clock behind a
// start/busy/done handshake, producing the result and CF/OF/SF/ZF/PF.
module shift_seq
  import shift_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [15:0]      x,
  input  logic [CNT_W-1:0] y,
  input  logic [1:0]       func,
  input  logic             word_op,
  input  logic             cfi,
  input  logic             ofi,
  output logic             busy,
  output logic             done,
  output logic [15:0]      out,
  output logic             cfo,
  output logic             ofo,
  output logic             sfo,
  output logic             zfo,
  output logic             pfo,
  output logic             flags_upd
);

  shf_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] v_q, v_d;
  shf_func_e         func_q, func_d;
  logic              word_op_q, word_op_d;
  logic              cf_q, cf_d;
  logic              of_q, of_d;
  logic              upd_q, upd_d;
  res_flags_t        flags_q, flags_d;

  logic [DATA_W-1:0] step_v;
  logic              step_cf;
  logic              step_prev_msb;

  shift_step u_step (
    .v        (v_q),
    .func     (func_q),
    .word_op  (word_op_q),
    .v_next   (step_v),
    .cf       (step_cf),
    .prev_msb (step_prev_msb)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    v_d       = v_q;
    func_d    = func_q;
    word_op_d = word_op_q;
    cf_d      = cf_q;
    of_d      = of_q;
    upd_d     = upd_q;
    flags_d   = flags_q;
    unique case (state_q)
      SHIFT: begin
        v_d   = step_v;
        cf_d  = step_cf;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          flags_d = res_flags(step_v, word_op_q);
          case (func_q)
            SHF_SHR: of_d = step_prev_msb;
            SHF_SAR: of_d = 1'b0;
            default: of_d = (word_op_q ? step_v[15] : step_v[7]) ^ step_cf;
          endcase
        end
      end
      default: begin
        // IDLE and DONE both accept a new request; DONE otherwise falls back to IDLE.
        state_d = IDLE;
        if (start) begin
          v_d       = x;
          func_d    = shf_func_e'(func);
          word_op_d = word_op;
          cf_d      = cfi;
          of_d      = ofi;
          cnt_d     = y;
          upd_d     = (y != '0);
          if (y == '0) begin
            state_d = DONE;
            flags_d = res_flags(x, word_op);
          end else begin
            state_d = SHIFT;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      v_q       <= '0;
      func_q    <= SHF_SHL;
      word_op_q <= 1'b0;
      cf_q      <= 1'b0;
      of_q      <= 1'b0;
      upd_q     <= 1'b0;
      flags_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      v_q       <= v_d;
      func_q    <= func_d;
      word_op_q <= word_op_d;
      cf_q      <= cf_d;
      of_q      <= of_d;
      upd_q     <= upd_d;
      flags_q   <= flags_d;
    end
  end

  assign busy      = (state_q == SHIFT);
  assign done      = (state_q == DONE);
  assign out       = v_q;
  assign cfo       = cf_q;
  assign ofo       = of_q;
  assign sfo       = flags_q.sf;
  assign zfo       = flags_q.zf;
  assign pfo       = flags_q.pf;
  assign flags_upd = upd_q;

endmodule
